// File: rtl/seg_codes_pkg.sv
// seg_codes_pkg: digit codes and converter state encoding shared with the seven-segment display side.
`default_nettype none

package seg_codes_pkg;

  localparam int DIGIT_CODE_W = 6;
  localparam logic [DIGIT_CODE_W-1:0] BLANK_CODE = 6'd16;
  localparam logic [DIGIT_CODE_W-1:0] DASH_CODE  = 6'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_adj3.sv
// bcd_adj3: double-dabble nibble correction, adds 3 when the BCD nibble is 5 or more.
`default_nettype none

module bcd_adj3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  assign q_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

`default_nettype wire

// File: rtl/bin_to_digit_codes.sv
// bin_to_digit_codes: one-bit-per-clock binary-to-BCD converter producing blanked/overflow-aware display codes.
// Rev 1.0
`default_nettype none

module bin_to_digit_codes
  import seg_codes_pkg::*;
#(
  parameter int                        WIDTH      = 14,
  parameter int                        DIGITS     = 4,
  parameter logic [DIGIT_CODE_W-1:0]   BLANK_CODE = seg_codes_pkg::BLANK_CODE,
  parameter logic [DIGIT_CODE_W-1:0]   DASH_CODE  = seg_codes_pkg::DASH_CODE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        value,
  input  logic                    start,
  output logic                    ready,
  output logic                    done,
  output logic                    ovf,
  output logic [DIGIT_CODE_W-1:0] dig3,
  output logic [DIGIT_CODE_W-1:0] dig2,
  output logic [DIGIT_CODE_W-1:0] dig1,
  output logic [DIGIT_CODE_W-1:0] dig0
);

  localparam int                 BCD_W    = 4 * DIGITS;
  localparam int                 SR_W     = BCD_W + WIDTH;
  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [31:0]        MAX_VAL  = 32'(10 ** DIGITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [WIDTH-1:0]        val_q, val_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [DIGIT_CODE_W-1:0] dig_q [DIGITS];
  logic [DIGIT_CODE_W-1:0] dig_d [DIGITS];

  logic [BCD_W-1:0]        adj;
  logic [SR_W-1:0]         sr_shifted;
  logic                    leading;
  logic [3:0]              nib;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i (sr_q[WIDTH + 4*g +: 4]),
      .q_o (adj[4*g +: 4])
    );
  end

  // The corrected top nibble's MSB falls off here; values that large are caught by the overflow compare.
  assign sr_shifted = {adj, sr_q[WIDTH-1:0]} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= BLANK_CODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      val_q   <= val_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    val_d   = val_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    leading = 1'b1;
    nib     = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          val_d   = value;
          sr_d    = {{BCD_W{1'b0}}, value};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FORMAT;
      end
      ST_FORMAT: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (32'(val_q) > MAX_VAL) begin
          ovf_d = 1'b1;
          for (int i = 0; i < DIGITS; i++) dig_d[i] = DASH_CODE;
        end else begin
          ovf_d = 1'b0;
          // Blank zeros from the most significant digit down until the first non-zero; the ones digit always shows.
          for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = sr_q[WIDTH + 4*i +: 4];
            if (leading && (nib == 4'd0) && (i != 0)) begin
              dig_d[i] = BLANK_CODE;
            end else begin
              dig_d[i] = {{(DIGIT_CODE_W-4){1'b0}}, nib};
              leading  = 1'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign dig3  = dig_q[3];
  assign dig2  = dig_q[2];
  assign dig1  = dig_q[1];
  assign dig0  = dig_q[0];

endmodule

`default_nettype wire
